icache_refill_unit: RTL and testbench

- Refill engine directly downstream of the I-cache main FSM: turns its read request into one AXI4 INCR burst for one cache line.
- Collects returned beats into a line buffer and signals completion so the FSM writes way memory and tag/valid in its REFILL state.
- Provides the FSM's r_rdy_AXI and fill_finish inputs; consumes its r_req and r_data_ready outputs.

---
 rtl/icache_refill_unit_if.sv | 28 ++
 rtl/icache_refill_unit.sv | 94 +++++++++
 tb/tb_icache_refill_unit.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/icache_refill_unit_if.sv
// AXI4 read-address and read-data channels between the I-cache refill engine
// (master) and the memory-side slave.
interface icache_refill_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic [3:0]            arid;
  logic                  rvalid;
  logic                  rready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rlast;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, arid, rready,
    input  arready, rvalid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, arid, rready,
    output arready, rvalid, rdata, rresp, rlast
  );
endinterface

// File: rtl/icache_refill_unit.sv
// I-cache refill engine: turns a miss request into one AXI4 INCR burst and
// assembles the returned beats into a cache line for the main FSM.
module icache_refill_unit #(
  parameter int         ADDR_WIDTH  = 32,
  parameter int         LINE_WORDS  = 16,
  parameter int         OFFSET_BITS = 6,
  parameter logic [3:0] AXI_ID      = 4'd0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       r_req,
  input  logic [ADDR_WIDTH-1:0]      r_addr,
  input  logic                       r_data_ready,
  output logic                       r_rdy,
  output logic                       fill_finish,
  output logic [LINE_WORDS*32-1:0]   line_data,
  output logic                       refill_err,
  icache_refill_unit_if.master       axi
);

  localparam int               CNT_W    = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic                     err;
  logic [ADDR_WIDTH-1:0]    araddr_q;
  logic [LINE_WORDS*32-1:0] line_q;
  logic                     beat_ok;
  logic                     last_beat;
  logic                     unused_offset;

  // The byte offset of the miss is irrelevant: the whole line is fetched.
  assign unused_offset = ^r_addr[OFFSET_BITS-1:0];

  assign beat_ok   = (state == DATA) && axi.rvalid && r_data_ready;
  assign last_beat = axi.rlast || (cnt == LAST_IDX);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      err      <= 1'b0;
      araddr_q <= '0;
      line_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (r_req) begin
            araddr_q <= {r_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            cnt      <= '0;
            err      <= 1'b0;
            state    <= ADDR;
          end
        end
        ADDR: begin
          if (axi.arready) state <= DATA;
        end
        DATA: begin
          if (beat_ok) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
              if (cnt == CNT_W'(i)) line_q[32*i +: 32] <= axi.rdata;
            end
            // Counter saturates on the final word so it never wraps mid-burst.
            if (cnt != LAST_IDX) cnt <= cnt + 1'b1;
            // A slave error or an rlast before the final word both poison the line.
            if ((axi.rresp != 2'b00) || (axi.rlast && (cnt != LAST_IDX))) err <= 1'b1;
            if (last_beat) state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign axi.arvalid = (state == ADDR);
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = 8'(LINE_WORDS - 1);
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;
  assign axi.arid    = AXI_ID;
  assign axi.rready  = (state == DATA) && r_data_ready;

  assign r_rdy       = (state == ADDR) && axi.arready;
  assign fill_finish = (state == DONE);
  assign refill_err  = (state == DONE) && err;
  assign line_data   = line_q;

endmodule

// File: tb/tb_icache_refill_unit.sv
// Randomized bench for icache_refill_unit: a transaction-level AXI slave plus a
// line model, with a per-cycle compare process on the handshake outputs.
module tb_icache_refill_unit;

  localparam int LW       = 16;
  localparam int PH_IDLE  = 0;
  localparam int PH_ADDR  = 1;
  localparam int PH_DATA  = 2;
  localparam int PH_DONE  = 3;

  logic              clk = 1'b0;
  logic              rstn;
  logic              r_req;
  logic [31:0]       r_addr;
  logic              r_data_ready;
  logic              r_rdy;
  logic              fill_finish;
  logic [LW*32-1:0]  line_data;
  logic              refill_err;

  icache_refill_unit_if #(.ADDR_WIDTH(32)) axi ();

  icache_refill_unit #(
    .ADDR_WIDTH(32), .LINE_WORDS(LW), .OFFSET_BITS(6), .AXI_ID(4'd0)
  ) dut (
    .clk(clk), .rstn(rstn), .r_req(r_req), .r_addr(r_addr),
    .r_data_ready(r_data_ready), .r_rdy(r_rdy), .fill_finish(fill_finish),
    .line_data(line_data), .refill_err(refill_err), .axi(axi)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          exp_phase = PH_IDLE;
  logic [31:0] exp_araddr = '0;
  logic [31:0] mdl_line [LW];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle handshake checks against the phase the stimulus has put the refill in.
  initial begin
    forever begin
      @(negedge clk);
      chk("arvalid", 32'(axi.arvalid), 32'(exp_phase == PH_ADDR));
      chk("r_rdy", 32'(r_rdy), 32'(exp_phase == PH_ADDR && axi.arready));
      chk("rready", 32'(axi.rready), 32'(exp_phase == PH_DATA && r_data_ready));
      chk("fill_finish", 32'(fill_finish), 32'(exp_phase == PH_DONE));
      if (exp_phase == PH_ADDR) chk("araddr", axi.araddr, exp_araddr);
      chk("arlen", 32'(axi.arlen), 32'd15);
      chk("arsize", 32'(axi.arsize), 32'd2);
      chk("arburst", 32'(axi.arburst), 32'd1);
      chk("arid", 32'(axi.arid), 32'd0);
    end
  end

  task automatic refill(input logic [31:0] addr, input int ar_wait, input bit stall,
                        input int err_beat, input int rlast_beat, input int abort_at,
                        input bit idx_data, output int lat, output logic err_seen,
                        output logic [31:0] ar_seen);
    logic [31:0] bd [LW];
    int          beat;
    int          n_beats;
    int          cyc;
    bit          exp_err;
    bit          pending;
    for (int i = 0; i < LW; i++) bd[i] = idx_data ? 32'(i) : $urandom;
    n_beats = (rlast_beat >= 0) ? rlast_beat + 1 : LW;
    exp_err = (err_beat >= 0 && err_beat < n_beats) || (rlast_beat >= 0 && rlast_beat < LW - 1);
    lat = -1; err_seen = 1'b0; ar_seen = '0; pending = 1'b0;
    exp_araddr = addr & 32'hFFFF_FFC0;
    exp_phase = PH_IDLE; r_req = 1'b1; r_addr = addr;
    axi.rvalid = 1'b0; axi.arready = 1'($urandom_range(0, 1));
    cyc = 0;
    @(posedge clk); #1; cyc++;
    // Request accepted: address phase, r_req is don't-care from here on.
    exp_phase = PH_ADDR; r_req = 1'($urandom_range(0, 1)); r_addr = $urandom;
    axi.arready = 1'b0; r_data_ready = 1'b1; axi.rvalid = 1'($urandom_range(0, 1));
    for (int i = 0; i < ar_wait; i++) begin @(posedge clk); #1; cyc++; end
    axi.arready = 1'b1;
    @(negedge clk); ar_seen = axi.araddr;
    @(posedge clk); #1; cyc++;
    exp_phase = PH_DATA; axi.arready = 1'($urandom_range(0, 1)); axi.rvalid = 1'b0;
    beat = 0;
    while (beat < n_beats) begin
      if (beat == abort_at) begin
        r_data_ready = 1'b1; axi.rvalid = 1'b1;
        #2; rstn = 1'b0; exp_phase = PH_IDLE; #1;
        chk("rst_arvalid", 32'(axi.arvalid), 32'd0);
        chk("rst_rready", 32'(axi.rready), 32'd0);
        chk("rst_fill_finish", 32'(fill_finish), 32'd0);
        chk("rst_araddr", axi.araddr, 32'd0);
        for (int i = 0; i < LW; i++) begin
          mdl_line[i] = '0;
          chk("rst_line_word", line_data[32*i +: 32], 32'd0);
        end
        @(posedge clk); #1;
        rstn = 1'b1; r_req = 1'b0; axi.rvalid = 1'b0;
        lat = cyc;
        return;
      end
      if (!pending) axi.rvalid = !stall || ($urandom_range(0, 2) != 0);
      r_data_ready = !stall || ($urandom_range(0, 2) != 0);
      axi.rdata = bd[beat];
      axi.rresp = (beat == err_beat) ? 2'b10 : 2'b00;
      axi.rlast = (beat == rlast_beat);
      @(negedge clk);
      if (axi.rvalid && r_data_ready) begin
        mdl_line[beat] = bd[beat]; beat++; pending = 1'b0;
      end else begin
        pending = axi.rvalid;
      end
      @(posedge clk); #1; cyc++;
      r_req = 1'($urandom_range(0, 1));
      if (cyc > 1000) begin
        vectors++; miscompares++;
        $display("FAIL refill_timeout: got %0d beats after %0d cycles, expected %0d", beat, cyc, n_beats);
        return;
      end
    end
    exp_phase = PH_DONE; axi.rvalid = 1'b0; axi.rlast = 1'b0;
    r_data_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    lat = cyc; err_seen = refill_err;
    chk("refill_err", 32'(refill_err), 32'(exp_err));
    for (int i = 0; i < LW; i++) chk("line_word", line_data[32*i +: 32], mdl_line[i]);
    @(posedge clk); #1;
    exp_phase = PH_IDLE; r_req = 1'b0;
  endtask

  int          lat;
  logic        e;
  logic [31:0] a;

  initial begin
    rstn = 1'b0; r_req = 1'b0; r_addr = '0; r_data_ready = 1'b0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0;
    for (int i = 0; i < LW; i++) mdl_line[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_araddr", axi.araddr, 32'd0);
    chk("reset_line_lo", line_data[31:0], 32'd0);
    chk("reset_line_hi", line_data[511:480], 32'd0);
    chk("reset_refill_err", 32'(refill_err), 32'd0);
    @(posedge clk); #1; rstn = 1'b1;
    @(posedge clk); #1;

    // Zero-wait refill, data = beat index.
    refill(32'h1000_0034, 0, 1'b0, -1, LW - 1, -1, 1'b1, lat, e, a);
    chk("t1_latency", 32'(lat), 32'd18);
    chk("t1_araddr", a, 32'h1000_0000);
    chk("t1_err", 32'(e), 32'd0);
    chk("t1_word5", line_data[191:160], 32'd5);
    chk("t1_word15", line_data[511:480], 32'd15);

    // Slow AR channel.
    refill(32'h2345_67FC, 5, 1'b0, -1, LW - 1, -1, 1'b0, lat, e, a);
    chk("t2_latency", 32'(lat), 32'd23);
    chk("t2_araddr", a, 32'h2345_67C0);

    // Random rvalid gaps and r_data_ready toggling.
    repeat (3) refill($urandom, $urandom_range(0, 3), 1'b1, -1, LW - 1, -1, 1'b0, lat, e, a);

    // Slave error on beat 7, then a clean line.
    refill($urandom, 0, 1'b0, 7, LW - 1, -1, 1'b0, lat, e, a);
    chk("t4_err", 32'(e), 32'd1);
    chk("t4_latency", 32'(lat), 32'd18);
    refill($urandom, 0, 1'b0, -1, LW - 1, -1, 1'b0, lat, e, a);
    chk("t4_clean_err", 32'(e), 32'd0);

    // Early rlast on beat 9, immediately followed by the next request.
    refill($urandom, 0, 1'b0, -1, 9, -1, 1'b0, lat, e, a);
    chk("t5_err", 32'(e), 32'd1);
    chk("t5_latency", 32'(lat), 32'd12);
    refill($urandom, 0, 1'b0, -1, LW - 1, -1, 1'b0, lat, e, a);
    chk("t5_b2b_latency", 32'(lat), 32'd18);
    chk("t5_b2b_err", 32'(e), 32'd0);

    // Full line without rlast.
    refill($urandom, 0, 1'b1, -1, -1, -1, 1'b0, lat, e, a);
    chk("t6_err", 32'(e), 32'd0);

    // Reset mid-burst after beat 5, then a normal refill.
    refill($urandom, 0, 1'b0, -1, LW - 1, 5, 1'b0, lat, e, a);
    refill($urandom, 0, 1'b0, -1, LW - 1, -1, 1'b0, lat, e, a);
    chk("t7_latency", 32'(lat), 32'd18);

    // Random mix.
    for (int n = 0; n < 10; n++) begin
      int eb;
      int lb;
      int sel;
      eb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LW - 1)) : -1;
      sel = int'($urandom_range(0, 9));
      lb  = (sel < 7) ? LW - 1 : ((sel < 9) ? int'($urandom_range(0, LW - 1)) : -1);
      refill($urandom, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), eb, lb, -1, 1'b0, lat, e, a);
      repeat (int'($urandom_range(0, 2))) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
